// File: rtl/lift_scan_controller.sv
// SCAN lift controller for an N-floor shaft.
// Latches hall/car calls, times travel and door dwell, drives stop info.
module lift_scan_controller #(
  parameter int N_FLOORS      = 5,
  parameter int FLOOR_W       = $clog2(N_FLOORS),
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] DirectionUp,
  input  logic [N_FLOORS-1:0] DirectionDown,
  input  logic [N_FLOORS-1:0] Floors,
  output logic [FLOOR_W-1:0]  NextFloor,
  output logic [1:0]          NextStopDirection,
  output logic [FLOOR_W-1:0]  CurrentFloor,
  output logic                DoorOpen,
  output logic [N_FLOORS-1:0] Pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);
  localparam logic [N_FLOORS-1:0] TOP_MASK = ~(ONE << (N_FLOORS - 1));
  localparam logic [N_FLOORS-1:0] BOT_MASK = ~ONE;
  localparam logic [N_FLOORS-1:0] NONE = '0;

  typedef enum logic [1:0] {
    IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN
  } state_t;

  state_t state, state_nx;
  logic [N_FLOORS-1:0] pend_up, pend_dn, pend_car;
  logic [N_FLOORS-1:0] pend_up_nx, pend_dn_nx, pend_car_nx;
  logic [FLOOR_W-1:0] floor_q, floor_nx;
  logic [FLOOR_W-1:0] next_floor_q, next_floor_nx;
  logic [TW-1:0] travel_q, travel_nx;
  logic [DW-1:0] door_q, door_nx;
  logic last_up, last_up_nx;
  logic served_up, served_up_nx;

  logic [N_FLOORS-1:0] pend_any, hi_c, lo_c, stop_u, stop_d;
  logic [N_FLOORS-1:0] any_nx, stop_u_nx, stop_d_nx;
  logic [N_FLOORS-1:0] in_up, in_dn, in_car, oh_cur, oh_nx;
  logic [FLOOR_W-1:0] arr_floor;
  logic above, below, here, here_up, here_dn;
  logic arr_stop, arr_srv, absorb;
  logic enter_door, srv_sel, go_up, go_dn;

  function automatic logic [N_FLOORS-1:0] higher(
    input logic [N_FLOORS-1:0] v
  );
    logic [N_FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < N_FLOORS; i++)
      for (int j = 0; j < N_FLOORS; j++)
        if (j > i && v[j]) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [N_FLOORS-1:0] lower(
    input logic [N_FLOORS-1:0] v
  );
    logic [N_FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < N_FLOORS; i++)
      for (int j = 0; j < N_FLOORS; j++)
        if (j < i && v[j]) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic pick(
    input logic [N_FLOORS-1:0] v,
    input logic [FLOOR_W-1:0]  f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (FLOOR_W'(i) == f) r = v[i];
    return r;
  endfunction

  function automatic logic [N_FLOORS-1:0] onehot(
    input logic [FLOOR_W-1:0] f
  );
    return ONE << f;
  endfunction

  function automatic logic [FLOOR_W-1:0] near_up(
    input logic [N_FLOORS-1:0] s,
    input logic [FLOOR_W-1:0]  f
  );
    logic [FLOOR_W-1:0] r;
    r = f;
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (FLOOR_W'(i) > f && s[i]) r = FLOOR_W'(i);
    return r;
  endfunction

  function automatic logic [FLOOR_W-1:0] near_dn(
    input logic [N_FLOORS-1:0] s,
    input logic [FLOOR_W-1:0]  f
  );
    logic [FLOOR_W-1:0] r;
    r = f;
    for (int i = 0; i < N_FLOORS; i++)
      if (FLOOR_W'(i) < f && s[i]) r = FLOOR_W'(i);
    return r;
  endfunction

  assign pend_any = pend_up | pend_dn | pend_car;
  assign hi_c = higher(pend_any);
  assign lo_c = lower(pend_any);
  assign stop_u = pend_car | pend_up | (pend_dn & ~hi_c);
  assign stop_d = pend_car | pend_dn | (pend_up & ~lo_c);

  assign above = pick(hi_c, floor_q);
  assign below = pick(lo_c, floor_q);
  assign here = pick(pend_any, floor_q);
  assign here_up = pick(pend_up, floor_q);
  assign here_dn = pick(pend_dn, floor_q);

  assign arr_floor = (state == MOVE_UP) ? floor_q + FLOOR_W'(1)
                                        : floor_q - FLOOR_W'(1);
  assign arr_stop = (state == MOVE_UP) ? pick(stop_u, arr_floor)
                                       : pick(stop_d, arr_floor);
  // Arriving with only the opposite call left at the end of the run
  // serves that call, so it turns the car around.
  assign arr_srv = (state == MOVE_UP)
    ? ~(pick(pend_dn, arr_floor) & ~pick(hi_c, arr_floor)
        & ~pick(pend_up, arr_floor))
    : (pick(pend_up, arr_floor) & ~pick(lo_c, arr_floor)
       & ~pick(pend_dn, arr_floor));

  // Next-state logic: transitions, timers, direction memory
  always_comb begin
    state_nx = state;
    floor_nx = floor_q;
    travel_nx = travel_q;
    door_nx = door_q;
    last_up_nx = last_up;
    served_up_nx = served_up;
    enter_door = 1'b0;
    srv_sel = last_up;
    go_up = 1'b0;
    go_dn = 1'b0;
    unique case (state)
      IDLE: begin
        if (here) begin
          enter_door = 1'b1;
          srv_sel = last_up ? (here_up | ~here_dn)
                            : (here_up & ~here_dn);
        end else if (above && below) begin
          go_up = last_up;
          go_dn = ~last_up;
        end else begin
          go_up = above;
          go_dn = below;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
          travel_nx = '0;
          floor_nx = arr_floor;
          if (arr_stop) begin
            enter_door = 1'b1;
            srv_sel = arr_srv;
          end
        end else begin
          travel_nx = travel_q + TW'(1);
        end
      end
      DOOR_OPEN: begin
        if (door_q == DW'(DOOR_CYCLES - 1)) begin
          door_nx = '0;
          state_nx = IDLE;
          go_up = above & (last_up | ~below);
          go_dn = below & (~last_up | ~above);
        end else begin
          door_nx = door_q + DW'(1);
        end
      end
    endcase
    if (go_up) begin
      state_nx = MOVE_UP;
      last_up_nx = 1'b1;
      travel_nx = '0;
    end
    if (go_dn) begin
      state_nx = MOVE_DOWN;
      last_up_nx = 1'b0;
      travel_nx = '0;
    end
    if (enter_door) begin
      state_nx = DOOR_OPEN;
      door_nx = '0;
      served_up_nx = srv_sel;
    end
  end

  assign oh_cur = onehot(floor_q);
  assign oh_nx = onehot(floor_nx);
  assign absorb = (state == DOOR_OPEN);

  assign in_car = Floors & ~(absorb ? oh_cur : NONE);
  assign in_up = DirectionUp & TOP_MASK
    & ~((absorb && served_up) ? oh_cur : NONE);
  assign in_dn = DirectionDown & BOT_MASK
    & ~((absorb && !served_up) ? oh_cur : NONE);

  assign pend_car_nx = (pend_car & ~(enter_door ? oh_nx : NONE))
    | in_car;
  assign pend_up_nx = (pend_up
    & ~((enter_door && srv_sel) ? oh_nx : NONE)) | in_up;
  assign pend_dn_nx = (pend_dn
    & ~((enter_door && !srv_sel) ? oh_nx : NONE)) | in_dn;

  assign any_nx = pend_up_nx | pend_dn_nx | pend_car_nx;
  assign stop_u_nx = pend_car_nx | pend_up_nx
    | (pend_dn_nx & ~higher(any_nx));
  assign stop_d_nx = pend_car_nx | pend_dn_nx
    | (pend_up_nx & ~lower(any_nx));

  assign next_floor_nx =
    (state_nx == MOVE_UP)   ? near_up(stop_u_nx, floor_nx) :
    (state_nx == MOVE_DOWN) ? near_dn(stop_d_nx, floor_nx) :
                              floor_nx;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      floor_q <= '0;
      next_floor_q <= '0;
      travel_q <= '0;
      door_q <= '0;
      last_up <= 1'b1;
      served_up <= 1'b1;
      pend_up <= '0;
      pend_dn <= '0;
      pend_car <= '0;
    end else begin
      state <= state_nx;
      floor_q <= floor_nx;
      next_floor_q <= next_floor_nx;
      travel_q <= travel_nx;
      door_q <= door_nx;
      last_up <= last_up_nx;
      served_up <= served_up_nx;
      pend_up <= pend_up_nx;
      pend_dn <= pend_dn_nx;
      pend_car <= pend_car_nx;
    end
  end

  // Output decode from the current state
  always_comb begin
    NextStopDirection = 2'b00;
    DoorOpen = 1'b0;
    unique case (state)
      MOVE_UP:   NextStopDirection = 2'b10;
      MOVE_DOWN: NextStopDirection = 2'b01;
      DOOR_OPEN: DoorOpen = 1'b1;
      default:   ;
    endcase
  end

  assign CurrentFloor = floor_q;
  assign NextFloor = next_floor_q;
  assign Pending = pend_any;

endmodule

// File: tb/tb_lift_scan_controller.sv
// Bench for lift_scan_controller: directed scenarios plus random calls
// checked every cycle against a floor-by-floor behavioural model.
module tb_lift_scan_controller;

  localparam int N = 5;
  localparam int TRAV = 2;
  localparam int DOOR = 3;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic clk;
  logic reset;
  logic [4:0] up_in, dn_in, car_in;
  logic [2:0] nf, cur;
  logic [1:0] dir;
  logic door;
  logic [4:0] pend;
  logic [7:0] car8_in;
  logic [7:0] zero8;
  logic [2:0] nf8, cur8;
  logic [1:0] dir8;
  logic door8;
  logic [7:0] pend8;

  int n_chk;
  int n_pass;

  int m_floor, m_mode, m_dir, m_left, m_srv, m_next;
  int m_up, m_dn, m_car;

  lift_scan_controller u_dut (
    .clk(clk),
    .reset(reset),
    .DirectionUp(up_in),
    .DirectionDown(dn_in),
    .Floors(car_in),
    .NextFloor(nf),
    .NextStopDirection(dir),
    .CurrentFloor(cur),
    .DoorOpen(door),
    .Pending(pend)
  );

  lift_scan_controller #(
    .N_FLOORS(8),
    .TRAVEL_CYCLES(1)
  ) u_dut8 (
    .clk(clk),
    .reset(reset),
    .DirectionUp(zero8),
    .DirectionDown(zero8),
    .Floors(car8_in),
    .NextFloor(nf8),
    .NextStopDirection(dir8),
    .CurrentFloor(cur8),
    .DoorOpen(door8),
    .Pending(pend8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
  endtask

  function automatic bit has(int v, int g);
    return ((v >> g) & 1) != 0;
  endfunction

  function automatic bit pend_at(int g);
    return has(m_up | m_dn | m_car, g);
  endfunction

  function automatic bit beyond(int f, int d);
    bit r;
    r = 0;
    for (int g = 0; g < N; g++)
      if ((g - f) * d > 0 && pend_at(g)) r = 1;
    return r;
  endfunction

  function automatic bit call_at(int g, int d);
    return has(d > 0 ? m_up : m_dn, g);
  endfunction

  function automatic bit stop_ok(int g, int d);
    return has(m_car, g) || call_at(g, d)
      || (call_at(g, -d) && !beyond(g, d));
  endfunction

  task automatic start_move(input int d);
    m_mode = M_MOVE;
    m_dir = d;
    m_left = TRAV;
  endtask

  task automatic model_reset();
    m_floor = 0; m_mode = M_IDLE; m_dir = 1; m_left = 0;
    m_srv = 1; m_next = 0; m_up = 0; m_dn = 0; m_car = 0;
  endtask

  task automatic model_step(input logic [4:0] u, d, c);
    int of, om, os, sf, ss, uu, dd, cc;
    bit found;
    of = m_floor; om = m_mode; os = m_srv; sf = -1; ss = 0;
    case (m_mode)
      M_IDLE: begin
        if (pend_at(m_floor)) begin
          sf = m_floor; ss = m_dir;
          if (!call_at(sf, ss) && call_at(sf, -ss)) ss = -ss;
        end else if (beyond(m_floor, 1) && beyond(m_floor, -1))
          start_move(m_dir);
        else if (beyond(m_floor, 1)) start_move(1);
        else if (beyond(m_floor, -1)) start_move(-1);
      end
      M_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_dir;
          m_left = TRAV;
          if (stop_ok(m_floor, m_dir)) begin
            sf = m_floor; ss = m_dir;
            if (!call_at(sf, ss) && call_at(sf, -ss)
                && !beyond(sf, ss)) ss = -ss;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (beyond(m_floor, m_dir)) start_move(m_dir);
          else if (beyond(m_floor, -m_dir)) start_move(-m_dir);
          else m_mode = M_IDLE;
        end
      end
    endcase
    if (sf >= 0) begin
      m_mode = M_DOOR; m_left = DOOR; m_srv = ss;
      m_car &= ~(1 << sf);
      if (ss > 0) m_up &= ~(1 << sf);
      else m_dn &= ~(1 << sf);
    end
    uu = int'(u) & ~(1 << (N - 1));
    dd = int'(d) & ~1;
    cc = int'(c);
    if (om == M_DOOR) begin
      cc &= ~(1 << of);
      if (os > 0) uu &= ~(1 << of);
      else dd &= ~(1 << of);
    end
    m_up |= uu; m_dn |= dd; m_car |= cc;
    m_next = m_floor;
    found = 0;
    if (m_mode == M_MOVE)
      for (int g = m_floor + m_dir; g >= 0 && g < N; g += m_dir)
        if (!found && stop_ok(g, m_dir)) begin
          m_next = g; found = 1;
        end
  endtask

  task automatic cycle(input logic [4:0] u, d, c, input logic [7:0] c8);
    up_in = u; dn_in = d; car_in = c; car8_in = c8;
    @(posedge clk);
    model_step(u, d, c);
    #1;
    chk("cur", cur, m_floor);
    chk("next", nf, m_next);
    chk("dir", dir, m_mode == M_MOVE ? (m_dir > 0 ? 2 : 1) : 0);
    chk("door", door, m_mode == M_DOOR);
    chk("pend", pend, m_up | m_dn | m_car);
    @(negedge clk);
  endtask

  task automatic mid_reset();
    up_in = '0; dn_in = '0; car_in = '0; car8_in = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_cur", cur, 0);
    chk("rst_next", nf, 0);
    chk("rst_dir", dir, 0);
    chk("rst_door", door, 0);
    chk("rst_pend", pend, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    zero8 = '0;
    up_in = '0; dn_in = '0; car_in = '0; car8_in = '0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_cur", cur, 0);
    chk("init_pend", pend, 0);
    reset = 1'b0;

    // single car call to floor 2, and floor 7 on the 8-floor shaft
    cycle(5'b0, 5'b0, 5'b00100, 8'h80);
    chk("t2_e0_pend", pend, 5'b00100);
    for (int e = 1; e <= 8; e++) begin
      cycle(5'b0, 5'b0, 5'b0, 8'h00);
      if (e == 1) begin
        chk("t2_e1_dir", dir, 2'b10);
        chk("t2_e1_next", nf, 2);
        chk("t8_e1_next", nf8, 7);
      end
      if (e == 3) chk("t2_e3_cur", cur, 1);
      if (e == 5) begin
        chk("t2_e5_cur", cur, 2);
        chk("t2_e5_door", door, 1);
        chk("t2_e5_dir", dir, 0);
      end
      if (e == 7) chk("t8_e7_cur", cur8, 6);
      if (e == 8) begin
        chk("t2_e8_door", door, 0);
        chk("t2_e8_pend", pend, 0);
        chk("t8_e8_cur", cur8, 7);
        chk("t8_e8_door", door8, 1);
      end
    end

    // car press at the open-door floor is absorbed
    cycle(5'b0, 5'b0, 5'b00100, 8'h00);
    cycle(5'b0, 5'b0, 5'b0, 8'h00);
    chk("t6_open", door, 1);
    cycle(5'b0, 5'b0, 5'b00100, 8'h00);
    chk("t6_absorb", pend, 0);
    cycle(5'b0, 5'b0, 5'b0, 8'h00);
    cycle(5'b0, 5'b0, 5'b0, 8'h00);
    chk("t6_close", door, 0);

    // calls with no meaning at the end floors are dropped
    cycle(5'b10000, 5'b00001, 5'b0, 8'h00);
    chk("t7_ignored", pend, 0);
    cycle(5'b0, 5'b0, 5'b0, 8'h00);
    chk("t7_idle", dir, 0);

    // calls on both sides while idle at 2, last direction up
    cycle(5'b00001, 5'b01000, 5'b0, 8'h00);
    for (int e = 1; e <= 15; e++) begin
      cycle(5'b0, 5'b0, 5'b0, 8'h00);
      if (e == 1) begin
        chk("t5_e1_dir", dir, 2'b10);
        chk("t5_e1_next", nf, 3);
      end
      if (e == 3) begin
        chk("t5_e3_cur", cur, 3);
        chk("t5_e3_door", door, 1);
      end
      if (e == 6) begin
        chk("t5_e6_dir", dir, 2'b01);
        chk("t5_e6_next", nf, 0);
      end
      if (e == 12) begin
        chk("t5_e12_cur", cur, 0);
        chk("t5_e12_door", door, 1);
      end
    end

    // trip to 4 with a hall up at 2 and a hall down at 3 added
    cycle(5'b0, 5'b0, 5'b10000, 8'h00);
    for (int e = 1; e <= 17; e++) begin
      if (e == 2) cycle(5'b00100, 5'b01000, 5'b0, 8'h00);
      else cycle(5'b0, 5'b0, 5'b0, 8'h00);
      if (e == 1) chk("t3_e1_next", nf, 4);
      if (e == 2) chk("t3_e2_next", nf, 2);
      if (e == 5) begin
        chk("t3_e5_cur", cur, 2);
        chk("t3_e5_door", door, 1);
      end
      if (e == 8) begin
        chk("t3_e8_dir", dir, 2'b10);
        chk("t3_e8_next", nf, 4);
      end
      if (e == 10) begin
        chk("t4_e10_cur", cur, 3);
        chk("t4_e10_door", door, 0);
      end
      if (e == 12) chk("t3_e12_door", door, 1);
      if (e == 15) begin
        chk("t4_e15_dir", dir, 2'b01);
        chk("t4_e15_next", nf, 3);
      end
      if (e == 17) begin
        chk("t4_e17_cur", cur, 3);
        chk("t4_e17_pend", pend, 0);
      end
    end

    // reset while travelling down
    cycle(5'b0, 5'b0, 5'b00001, 8'h00);
    for (int e = 0; e < 5; e++) cycle(5'b0, 5'b0, 5'b0, 8'h00);
    chk("rs_moving", dir, 2'b01);
    mid_reset();
    cycle(5'b0, 5'b0, 5'b0, 8'h00);
    cycle(5'b0, 5'b0, 5'b0, 8'h00);
    chk("rs_pend", pend, 0);

    // random calls
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] u, d, c;
      u = '0; d = '0; c = '0;
      case ($urandom_range(0, 11))
        0: u = 5'(1) << $urandom_range(0, 4);
        1: d = 5'(1) << $urandom_range(0, 4);
        2: c = 5'(1) << $urandom_range(0, 4);
        3: begin
          u = 5'(1) << $urandom_range(0, 4);
          d = 5'(1) << $urandom_range(0, 4);
        end
        default: ;
      endcase
      cycle(u, d, c, 8'h00);
      if (k % 1000 == 999) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
